// File: rtl/cnet_reprog_ctrl.sv
// cnet_reprog_ctrl
//   Bridges the CPCI reprogramming registers to the CNET SelectMAP configuration
//   port. Host data words are buffered in a small FIFO. A start request pulses
//   PROG_B, waits for INIT_B, then streams each word MSB-byte first with a
//   generated CCLK. Completion or failure is reported through sticky status bits.
//
// Ports
//   CLK, RST_N       system clock, asynchronous active-low reset
//   reprog_start     1-cycle start request (restarts from any state)
//   data_wr          1-cycle data write strobe, data_wr_data = word
//   data_full        FIFO full (host write must be retried)
//   status_busy      in PROG_LOW, WAIT_INIT or STREAM
//   status_done      configuration finished (CNET DONE observed)
//   status_error     INIT timeout, INIT_B low while streaming, or overflow
//   status_ovfl      a write arrived while full and was dropped
//   cnet_prog_b      CNET PROG_B
//   cnet_init_b      CNET INIT_B (asynchronous, synchronised here)
//   cnet_done        CNET DONE (asynchronous, synchronised here)
//   cnet_cclk        configuration clock
//   cnet_d           SelectMAP data byte
//   cnet_cs_b        chip select, active-low
//   cnet_rdwr_b      tied to write (0)

module cnet_reprog_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PROG_CYCLES  = 64,
    parameter int unsigned INIT_TIMEOUT = 4096,
    parameter int unsigned CCLK_HALF    = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        reprog_start,
    input  logic        data_wr,
    input  logic [31:0] data_wr_data,
    output logic        data_full,
    output logic        status_busy,
    output logic        status_done,
    output logic        status_error,
    output logic        status_ovfl,
    output logic        cnet_prog_b,
    input  logic        cnet_init_b,
    input  logic        cnet_done,
    output logic        cnet_cclk,
    output logic [7:0]  cnet_d,
    output logic        cnet_cs_b,
    output logic        cnet_rdwr_b
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_MAX = (PROG_CYCLES > INIT_TIMEOUT) ? PROG_CYCLES : INIT_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PH_W    = $clog2(2 * CCLK_HALF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG_LOW,
        S_WAIT_INIT,
        S_STREAM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [1:0] init_sync, done_sync;
    logic       init_s, done_s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_sync <= '0;
            done_sync <= '0;
        end else begin
            init_sync <= {init_sync[0], cnet_init_b};
            done_sync <= {done_sync[0], cnet_done};
        end
    end

    assign init_s = init_sync[1];
    assign done_s = done_sync[1];

    // ------------------------------------------------------------------
    // Data FIFO
    // ------------------------------------------------------------------
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full, fifo_empty;
    logic             push, pop, overflow;
    logic [31:0]      fifo_head;

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign fifo_head  = mem[rd_ptr];
    // A start flushes the FIFO, so a write in the same cycle is discarded.
    assign push       = data_wr && !fifo_full && !reprog_start;
    assign overflow   = data_wr &&  fifo_full && !reprog_start;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= data_wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (reprog_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte shifter state
    // ------------------------------------------------------------------
    logic            active;       // a byte is currently on cnet_d
    logic [PH_W-1:0] ph;           // cycle within the current byte
    logic [1:0]      bytes_left;   // bytes still waiting in sh
    logic [31:0]     sh;
    logic [7:0]      d_q;
    logic            cclk_q;
    logic            byte_done;
    logic            load_word, load_byte;

    // The shifter is free when idle or on the last cycle of the current byte.
    assign byte_done = !active || (ph == PH_W'(2 * CCLK_HALF - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_word  = 1'b0;
        load_byte  = 1'b0;
        if (reprog_start) begin
            state_next = S_PROG_LOW;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_IDLE;
                end
                S_PROG_LOW: begin
                    if (cnt == CNT_W'(PROG_CYCLES - 1)) begin
                        state_next = S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (init_s) begin
                        state_next = S_STREAM;
                    end else if (cnt == CNT_W'(INIT_TIMEOUT - 1)) begin
                        state_next = S_ERROR;
                    end
                end
                S_STREAM: begin
                    if (!init_s) begin
                        state_next = S_ERROR;
                    end else if (byte_done) begin
                        if (done_s) begin
                            state_next = S_DONE;
                        end else if (bytes_left != 2'd0) begin
                            load_byte = 1'b1;
                        end else if (!fifo_empty) begin
                            pop       = 1'b1;
                            load_word = 1'b1;
                        end
                    end
                end
                S_DONE:  state_next = S_DONE;
                S_ERROR: state_next = S_ERROR;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Shared counter: PROG_B low time in PROG_LOW, INIT_B timeout in WAIT_INIT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (reprog_start || (state_next != state)) begin
            cnt <= '0;
        end else if ((state == S_PROG_LOW) || (state == S_WAIT_INIT)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Status and pin registers are loaded from the next state so they change
    // on the same edge as the state register.
    logic prog_b_q, cs_b_q, busy_q, done_q, err_q, ovfl_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            prog_b_q <= 1'b1;
            cs_b_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovfl_q   <= 1'b0;
        end else begin
            state    <= state_next;
            prog_b_q <= (state_next != S_PROG_LOW);
            cs_b_q   <= (state_next != S_STREAM);
            busy_q   <= (state_next == S_PROG_LOW) || (state_next == S_WAIT_INIT) ||
                        (state_next == S_STREAM);
            done_q   <= (state_next == S_DONE);
            if (reprog_start) begin
                err_q  <= 1'b0;
                ovfl_q <= 1'b0;
            end else begin
                if ((state_next == S_ERROR) || overflow) begin
                    err_q <= 1'b1;
                end
                if (overflow) begin
                    ovfl_q <= 1'b1;
                end
            end
        end
    end

    // Byte streaming: d changes with cclk low, cclk rises after CCLK_HALF
    // cycles and stays high for CCLK_HALF cycles.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            active     <= 1'b0;
            ph         <= '0;
            bytes_left <= '0;
            sh         <= '0;
            d_q        <= '0;
            cclk_q     <= 1'b0;
        end else if (reprog_start) begin
            active     <= 1'b0;
            ph         <= '0;
            bytes_left <= '0;
            sh         <= '0;
            d_q        <= '0;
            cclk_q     <= 1'b0;
        end else if ((state == S_STREAM) && (state_next == S_STREAM)) begin
            if (load_word) begin
                d_q        <= fifo_head[31:24];
                sh         <= {fifo_head[23:0], 8'h00};
                bytes_left <= 2'd3;
                ph         <= '0;
                active     <= 1'b1;
                cclk_q     <= 1'b0;
            end else if (load_byte) begin
                d_q        <= sh[31:24];
                sh         <= {sh[23:0], 8'h00};
                bytes_left <= bytes_left - 2'd1;
                ph         <= '0;
                active     <= 1'b1;
                cclk_q     <= 1'b0;
            end else if (active) begin
                if (byte_done) begin
                    // Nothing left to send: stall with cclk low, d held.
                    active <= 1'b0;
                    cclk_q <= 1'b0;
                end else begin
                    ph <= ph + PH_W'(1);
                    if (ph == PH_W'(CCLK_HALF - 1)) begin
                        cclk_q <= 1'b1;
                    end
                end
            end
        end else begin
            active <= 1'b0;
            ph     <= '0;
            cclk_q <= 1'b0;
        end
    end

    assign data_full    = fifo_full;
    assign status_busy  = busy_q;
    assign status_done  = done_q;
    assign status_error = err_q;
    assign status_ovfl  = ovfl_q;
    assign cnet_prog_b  = prog_b_q;
    assign cnet_cclk    = cclk_q;
    assign cnet_d       = d_q;
    assign cnet_cs_b    = cs_b_q;
    assign cnet_rdwr_b  = 1'b0;

endmodule

// File: tb/tb_cnet_reprog_ctrl.sv
// tb_cnet_reprog_ctrl
//   Scenario tasks drive the host side and the CNET INIT_B/DONE pins. A monitor
//   records every byte presented on a cclk rising edge; expected bytes come from
//   the words the host had accepted, split MSB first.

module tb_cnet_reprog_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PROGC = 64;
    localparam int unsigned TMO   = 4096;
    localparam int unsigned HALF  = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        reprog_start = 1'b0;
    logic        data_wr = 1'b0;
    logic [31:0] data_wr_data = '0;
    logic        data_full, status_busy, status_done, status_error, status_ovfl;
    logic        cnet_prog_b, cnet_cclk, cnet_cs_b, cnet_rdwr_b;
    logic [7:0]  cnet_d;
    logic        cnet_init_b = 1'b0;
    logic        cnet_done = 1'b0;

    always #5 CLK = ~CLK;

    cnet_reprog_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .PROG_CYCLES (PROGC),
        .INIT_TIMEOUT(TMO),
        .CCLK_HALF   (HALF)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .reprog_start(reprog_start),
        .data_wr     (data_wr),
        .data_wr_data(data_wr_data),
        .data_full   (data_full),
        .status_busy (status_busy),
        .status_done (status_done),
        .status_error(status_error),
        .status_ovfl (status_ovfl),
        .cnet_prog_b (cnet_prog_b),
        .cnet_init_b (cnet_init_b),
        .cnet_done   (cnet_done),
        .cnet_cclk   (cnet_cclk),
        .cnet_d      (cnet_d),
        .cnet_cs_b   (cnet_cs_b),
        .cnet_rdwr_b (cnet_rdwr_b)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       cclk_prev = 1'b0;

    always @(negedge CLK) begin
        if (cnet_cclk === 1'b1 && cclk_prev === 1'b0) begin
            rx_q.push_back(cnet_d);
        end
        cclk_prev = cnet_cclk;
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        reprog_start = 1'b1;
        step();
        reprog_start = 1'b0;
    endtask

    task automatic measure_prog_low(output int n);
        n = 0;
        while (cnet_prog_b === 1'b0 && n < int'(PROGC) * 4) begin
            n++;
            step();
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        data_wr      = 1'b1;
        data_wr_data = w;
        step();
        data_wr      = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) begin
            exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic write_fc(input logic [31:0] w, output bit ok);
        int t;
        t = 0;
        while (data_full === 1'b1 && t < 1000) begin
            step();
            t++;
        end
        ok = (data_full === 1'b0);
        if (ok) begin
            push_word(w);
        end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            step();
            t++;
        end
        ok = (rx_q.size() >= n);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [16:0] obs;
        logic [16:0] exp_rst;
        int n;
        bit ok;
        exp_rst = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'b00000};

        RST_N = 1'b0;
        repeat (3) step();
        obs = {cnet_prog_b, cnet_cclk, cnet_d, cnet_cs_b, cnet_rdwr_b,
               status_busy, status_done, status_error, status_ovfl, data_full};
        n_cmp++;
        if (obs !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", obs, exp_rst);
        end
        RST_N = 1'b1;
        step();

        // Get a stream going, then pull reset asynchronously mid-byte.
        cnet_init_b = 1'b0;
        pulse_start();
        measure_prog_low(n);
        push_word($urandom);
        push_word($urandom);
        cnet_init_b = 1'b1;
        wait_rx(3, 300, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_stream_setup: got %0d bytes expected >=3", rx_q.size());
        end
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        obs = {cnet_prog_b, cnet_cclk, cnet_d, cnet_cs_b, cnet_rdwr_b,
               status_busy, status_done, status_error, status_ovfl, data_full};
        n_cmp++;
        if (obs !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", obs, exp_rst);
        end
        step();
        step();
        RST_N = 1'b1;
        n = rx_q.size();
        repeat (20) step();
        // IDLE: no activity even with INIT_B high.
        obs = {cnet_prog_b, cnet_cclk, cnet_d, cnet_cs_b, cnet_rdwr_b,
               status_busy, status_done, status_error, status_ovfl, data_full};
        n_cmp++;
        if (obs !== exp_rst) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs, exp_rst);
        end
        n_cmp++;
        if (rx_q.size() !== n) begin
            n_fail++;
            $display("FAIL reset_idle_cclk: got %0d bytes expected %0d", rx_q.size(), n);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream_basic();
        int n;
        bit ok;
        logic [31:0] w;
        cnet_init_b = 1'b0;
        cnet_done   = 1'b0;
        pulse_start();
        rx_q.delete();
        exp_q.delete();
        measure_prog_low(n);
        n_cmp++;
        if (n !== int'(PROGC)) begin
            n_fail++;
            $display("FAIL basic_prog_low: got %0d cycles expected %0d", n, PROGC);
        end
        push_word(32'hA1B2C3D4);
        expect_word(32'hA1B2C3D4);
        for (int k = 0; k < 3; k++) begin
            w = $urandom;
            push_word(w);
            expect_word(w);
        end
        repeat (6) step();
        cnet_init_b = 1'b1;
        wait_rx(16, 500, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: got %0d bytes expected 16", rx_q.size());
        end
        repeat (40) step();
        n_cmp++;
        if (rx_q.size() !== 16) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d expected 16", rx_q.size());
        end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        // Stalled on empty FIFO: cclk low, d holds the last byte, no error.
        n_cmp++;
        if ({status_busy, status_error, cnet_cclk, cnet_cs_b, cnet_d} !== {4'b1000, exp_q[15]}) begin
            n_fail++;
            $display("FAIL basic_stall: got %b_%h expected 1000_%h",
                     {status_busy, status_error, cnet_cclk, cnet_cs_b}, cnet_d, exp_q[15]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow();
        int n;
        bit ok;
        logic [31:0] w;
        cnet_init_b = 1'b0;
        pulse_start();
        rx_q.delete();
        exp_q.delete();
        measure_prog_low(n);
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            push_word(w);
            expect_word(w);
        end
        n_cmp++;
        if ({data_full, status_ovfl, status_error} !== 3'b100) begin
            n_fail++;
            $display("FAIL ovfl_full4: got %b expected 100", {data_full, status_ovfl, status_error});
        end
        push_word($urandom);
        n_cmp++;
        if ({data_full, status_ovfl, status_error} !== 3'b111) begin
            n_fail++;
            $display("FAIL ovfl_drop5: got %b expected 111", {data_full, status_ovfl, status_error});
        end
        cnet_init_b = 1'b1;
        wait_rx(16, 500, ok);
        repeat (40) step();
        n_cmp++;
        if (rx_q.size() !== 16) begin
            n_fail++;
            $display("FAIL ovfl_count: got %0d bytes expected 16", rx_q.size());
        end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovfl_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_init_timeout();
        int n;
        int k;
        cnet_init_b = 1'b0;
        pulse_start();
        n_cmp++;
        if (status_error !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: got error=%b expected 0", status_error);
        end
        measure_prog_low(n);
        k = 0;
        while (status_error !== 1'b1 && k < int'(TMO) + 100) begin
            step();
            k++;
        end
        n_cmp++;
        if (k !== int'(TMO)) begin
            n_fail++;
            $display("FAIL tmo_cycles: got %0d expected %0d", k, TMO);
        end
        n_cmp++;
        if ({status_busy, status_error, cnet_prog_b, cnet_cs_b, cnet_cclk} !== 5'b01110) begin
            n_fail++;
            $display("FAIL tmo_state: got %b expected 01110",
                     {status_busy, status_error, cnet_prog_b, cnet_cs_b, cnet_cclk});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_crc_error();
        int n;
        int k;
        bit ok;
        logic [31:0] w;
        cnet_init_b = 1'b0;
        pulse_start();
        rx_q.delete();
        exp_q.delete();
        measure_prog_low(n);
        for (int j = 0; j < 4; j++) begin
            w = $urandom;
            push_word(w);
            expect_word(w);
        end
        cnet_init_b = 1'b1;
        wait_rx(3, 300, ok);
        cnet_init_b = 1'b0;
        k = 0;
        while (status_error !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        n_cmp++;
        if ({status_error, status_busy, cnet_cs_b, cnet_cclk, cnet_prog_b} !== 5'b10101) begin
            n_fail++;
            $display("FAIL crc_state: got %b expected 10101",
                     {status_error, status_busy, cnet_cs_b, cnet_cclk, cnet_prog_b});
        end
        // The 4th byte is loaded before the synchronised INIT_B low arrives but
        // ERROR is entered before its cclk rises.
        n_cmp++;
        if (rx_q.size() !== 3) begin
            n_fail++;
            $display("FAIL crc_bytes: got %0d expected 3", rx_q.size());
        end
        pulse_start();
        n_cmp++;
        if ({status_error, status_busy, cnet_prog_b} !== 3'b010) begin
            n_fail++;
            $display("FAIL crc_restart: got %b expected 010",
                     {status_error, status_busy, cnet_prog_b});
        end
        measure_prog_low(n);
        n_cmp++;
        if (n !== int'(PROGC)) begin
            n_fail++;
            $display("FAIL crc_prog_low: got %0d expected %0d", n, PROGC);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_done();
        int n;
        int k;
        bit ok;
        logic [31:0] w;
        cnet_init_b = 1'b0;
        cnet_done   = 1'b0;
        pulse_start();
        rx_q.delete();
        exp_q.delete();
        measure_prog_low(n);
        for (int j = 0; j < 4; j++) begin
            w = $urandom;
            push_word(w);
            expect_word(w);
        end
        cnet_init_b = 1'b1;
        wait_rx(8, 300, ok);
        cnet_done = 1'b1;
        k = 0;
        while (status_done !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        n_cmp++;
        if ({status_done, status_busy, status_error, cnet_cs_b, cnet_cclk} !== 5'b10010) begin
            n_fail++;
            $display("FAIL done_state: got %b expected 10010",
                     {status_done, status_busy, status_error, cnet_cs_b, cnet_cclk});
        end
        // DONE is synchronised, so the byte already loaded when it arrives
        // completes: 9 bytes total.
        n_cmp++;
        if (rx_q.size() !== 9) begin
            n_fail++;
            $display("FAIL done_bytes: got %0d expected 9", rx_q.size());
        end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL done_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
            end
        end
        push_word($urandom);
        repeat (30) step();
        n_cmp++;
        if ({rx_q.size() == 9, status_done, cnet_cclk} !== 3'b110) begin
            n_fail++;
            $display("FAIL done_hold: got bytes=%0d done=%b cclk=%b expected 9 1 0",
                     rx_q.size(), status_done, cnet_cclk);
        end
        cnet_done = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int n;
        int dly, n0, ntot;
        bit ok;
        logic [31:0] w;
        for (int it = 0; it < 3; it++) begin
            cnet_init_b = 1'b0;
            cnet_done   = 1'b0;
            pulse_start();
            rx_q.delete();
            exp_q.delete();
            measure_prog_low(n);
            n_cmp++;
            if (n !== int'(PROGC)) begin
                n_fail++;
                $display("FAIL b2b%0d_prog_low: got %0d expected %0d", it, n, PROGC);
            end
            dly  = $urandom_range(3, 30);
            n0   = $urandom_range(1, 4);
            ntot = $urandom_range(6, 10);
            for (int j = 0; j < n0; j++) begin
                w = $urandom;
                push_word(w);
                expect_word(w);
            end
            repeat (dly) step();
            cnet_init_b = 1'b1;
            for (int j = n0; j < ntot; j++) begin
                w = $urandom;
                write_fc(w, ok);
                n_cmp++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL b2b%0d_full_stuck: got full=%b expected 0", it, data_full);
                end else begin
                    expect_word(w);
                end
            end
            wait_rx(exp_q.size(), 2000, ok);
            repeat (20) step();
            n_cmp++;
            if (rx_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL b2b%0d_count: got %0d expected %0d", it, rx_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b%0d_byte%0d: got %h expected %h", it, i, rx_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if ({status_busy, status_error, status_ovfl} !== 3'b100) begin
                n_fail++;
                $display("FAIL b2b%0d_status: got %b expected 100", it,
                         {status_busy, status_error, status_ovfl});
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream_basic();
        test_overflow();
        test_init_timeout();
        test_crc_error();
        test_done();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
